// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: bus widths,
// write-enable encodings, the pipeline port index and the grant-kind enum.
package regfile_wr_arbiter_pkg;

  localparam int REG_ADDR_BUS = 5;
  localparam int REG_BUS      = 32;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic RST_ENABLE    = 1'b1;

  localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

  // Index of the main pipeline writeback port (fixed highest priority).
  localparam int REQ_PIPE = 0;

  // Which path produced this cycle's grant.
  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_LOW,
    GNT_STARVE
  } gnt_kind_e;

  // Increment an index in the range 0..n-1, wrapping back to 0.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_rr.sv
// Rotating-priority one-hot picker for the multi-cycle writeback ports.
// Local index 0 corresponds to top-level port 1. The pointer names the
// highest-priority input and moves past the winner whenever the grant is taken.
module regfile_wr_arbiter_rr
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win;
  logic          found;

  // Pick the first requester at or after the pointer, then wrap to the lower indices.
  always_comb begin
    gnt   = '0;
    win   = ptr_q;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && (i >= int'(ptr_q)) && req[i]) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        win    = PW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && (i < int'(ptr_q)) && req[i]) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        win    = PW'(i);
      end
    end
  end

  // Move priority to the input just after the winner, only when the grant is used.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = PW'(wrap_inc(int'(win), N));
    end
  end

  // Pointer register; reset points at the first multi-cycle port.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter. Port 0 (pipeline WB) wins by default;
// ports 1..NREQ-1 share the leftover cycles round-robin, and a starvation
// counter forces one low-port grant after STARVE_MAX cycles of waiting.
// The grant is registered onto we/waddr/wdata; pending low-port writes are
// compared against the decode read addresses for RAW stalls.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int STARVE_MAX = 8,
  parameter int AW         = REG_ADDR_BUS,
  parameter int DW         = REG_BUS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [AW-1:0]      chk_addr1,
  input  logic [AW-1:0]      chk_addr2,
  output logic               pend_hit1,
  output logic               pend_hit2,
  output logic               we_o,
  output logic [AW-1:0]      waddr_o,
  output logic [DW-1:0]      wdata_o,
  output logic               starve_o
);

  localparam int NLOW = NREQ - 1;
  localparam int CW   = $clog2(STARVE_MAX + 1);

  gnt_kind_e         kind;
  logic [NLOW-1:0]   low_valid, low_gnt;
  logic              any_low, low_take;
  logic [AW-1:0]     gnt_addr;
  logic [DW-1:0]     gnt_data;
  logic [CW-1:0]     starve_cnt_q, starve_cnt_d;
  logic              we_q, we_d;
  logic [AW-1:0]     waddr_q, waddr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [NREQ-1:0]   hit1_vec, hit2_vec;

  assign low_valid = req_valid[NREQ-1:1];
  assign any_low   = |low_valid;

  regfile_wr_arbiter_rr #(.N(NLOW)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (low_valid),
    .advance (low_take),
    .gnt     (low_gnt)
  );

  // Decide who owns the write port this cycle; nothing transfers in reset.
  always_comb begin
    kind = GNT_NONE;
    if (rst == RST_ENABLE) begin
      kind = GNT_NONE;
    end else if ((starve_cnt_q == CW'(STARVE_MAX)) && any_low) begin
      kind = GNT_STARVE;
    end else if (req_valid[REQ_PIPE]) begin
      kind = GNT_PIPE;
    end else if (any_low) begin
      kind = GNT_LOW;
    end
    low_take  = (kind == GNT_STARVE) || (kind == GNT_LOW);
    starve_o  = (kind == GNT_STARVE);
    req_ready = {(low_take ? low_gnt : {NLOW{1'b0}}), (kind == GNT_PIPE)};
  end

  // Select the granted port's address and data (req_ready is one-hot or zero).
  always_comb begin
    gnt_addr = '0;
    gnt_data = ZERO_WORD[DW-1:0];
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        gnt_addr = req_addr[i*AW +: AW];
        gnt_data = req_data[i*DW +: DW];
      end
    end
  end

  // Count cycles a low port waits; any low grant or an empty low side clears it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!any_low || low_take) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != CW'(STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // Next regfile write: writes to r0 are issued with the enable held low.
  always_comb begin
    we_d    = WRITE_DISABLE;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (kind != GNT_NONE) begin
      we_d    = (gnt_addr != '0) ? WRITE_ENABLE : WRITE_DISABLE;
      waddr_d = gnt_addr;
      wdata_d = gnt_data;
    end
  end

  // State and output registers; reset cancels any in-flight write.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      starve_cnt_q <= '0;
      we_q         <= WRITE_DISABLE;
      waddr_q      <= '0;
      wdata_q      <= ZERO_WORD[DW-1:0];
    end else begin
      starve_cnt_q <= starve_cnt_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign we_o    = we_q;
  assign waddr_o = waddr_q;
  assign wdata_o = wdata_q;

  // Port 0 writes retire through the normal pipeline bypass, so only low ports count.
  assign hit1_vec[0] = 1'b0;
  assign hit2_vec[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NREQ; gi++) begin : g_haz
      logic pend;
      assign pend         = req_valid[gi] && !req_ready[gi];
      assign hit1_vec[gi] = pend && (req_addr[gi*AW +: AW] == chk_addr1);
      assign hit2_vec[gi] = pend && (req_addr[gi*AW +: AW] == chk_addr2);
    end
  endgenerate

  assign pend_hit1 = (rst != RST_ENABLE) && (chk_addr1 != '0) && (|hit1_vec);
  assign pend_hit2 = (rst != RST_ENABLE) && (chk_addr2 != '0) && (|hit2_vec);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios followed by
// random traffic, all checked against a cycle-level reference model.
module tb_regfile_wr_arbiter;

  localparam int NREQ = 3;
  localparam int SMAX = 8;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid, req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [AW-1:0]      chk_addr1, chk_addr2;
  logic               pend_hit1, pend_hit2, we_o, starve_o;
  logic [AW-1:0]      waddr_o;
  logic [DW-1:0]      wdata_o;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.NREQ(NREQ), .STARVE_MAX(SMAX), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .pend_hit1 (pend_hit1),
    .pend_hit2 (pend_hit2),
    .we_o      (we_o),
    .waddr_o   (waddr_o),
    .wdata_o   (wdata_o),
    .starve_o  (starve_o)
  );

  int checks = 0;
  int errors = 0;

  // Requester state as seen by the bench.
  logic          v[NREQ];
  logic [AW-1:0] a[NREQ];
  logic [DW-1:0] d[NREQ];

  // Reference model state.
  int            m_rr;
  int            m_starve;
  logic          e_we;
  logic [AW-1:0] e_waddr;
  logic [DW-1:0] e_wdata;
  logic          e_chkdata;
  logic          e_known;
  int            g_last;

  // DUT samples from the most recent step.
  logic [NREQ-1:0] rdy_s;
  logic            st_s, ph1_s, ph2_s, we_s;
  logic [AW-1:0]   wa_s;
  logic [DW-1:0]   wd_s;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin choice: first valid low port starting at m_rr, wrapping NREQ-1 -> 1.
  function automatic int rr_pick();
    int p;
    for (int k = 0; k < NREQ - 1; k++) begin
      p = 1 + ((m_rr - 1 + k) % (NREQ - 1));
      if (v[p]) return p;
    end
    return -1;
  endfunction

  // A decode address hits when some low port other than the winner still waits on it.
  function automatic logic hit(input logic [AW-1:0] c, input int g);
    if (rst || c == '0) return 1'b0;
    for (int i = 1; i < NREQ; i++) begin
      if (v[i] && i != g && a[i] == c) return 1'b1;
    end
    return 1'b0;
  endfunction

  // One clock: apply inputs, check combinational and registered outputs, advance the model.
  task automatic tick(input string tag);
    int              g;
    bit              any_low;
    logic [NREQ-1:0] e_rdy;
    logic            e_st;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]             = v[i];
      req_addr[i*AW +: AW]     = a[i];
      req_data[i*DW +: DW]     = d[i];
    end
    #4;
    rdy_s = req_ready;
    st_s  = starve_o;
    ph1_s = pend_hit1;
    ph2_s = pend_hit2;
    we_s  = we_o;
    wa_s  = waddr_o;
    wd_s  = wdata_o;
    if (e_known) begin
      chk({tag, "_we"}, we_o, e_we);
      if (e_chkdata) begin
        chk({tag, "_waddr"}, waddr_o, e_waddr);
        chk({tag, "_wdata"}, wdata_o, e_wdata);
      end
    end
    any_low = 1'b0;
    for (int i = 1; i < NREQ; i++) any_low |= v[i];
    g    = -1;
    e_st = 1'b0;
    if (rst) g = -1;
    else if (m_starve == SMAX && any_low) begin
      g    = rr_pick();
      e_st = 1'b1;
    end else if (v[0]) g = 0;
    else if (any_low) g = rr_pick();
    e_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
    chk({tag, "_ready"},  req_ready, e_rdy);
    chk({tag, "_starve"}, starve_o,  e_st);
    chk({tag, "_hit1"},   pend_hit1, hit(chk_addr1, g));
    chk({tag, "_hit2"},   pend_hit2, hit(chk_addr2, g));
    if (rst) begin
      e_we = 1'b0; e_waddr = '0; e_wdata = '0; e_chkdata = 1'b1;
      m_rr = 1; m_starve = 0;
    end else begin
      if (g >= 0) begin
        e_we      = (a[g] != '0);
        e_waddr   = a[g];
        e_wdata   = d[g];
        e_chkdata = e_we;
      end else begin
        e_we      = 1'b0;
        e_chkdata = 1'b0;
      end
      if (g >= 1) begin
        m_rr     = (g == NREQ - 1) ? 1 : g + 1;
        m_starve = 0;
      end else if (!any_low) m_starve = 0;
      else if (m_starve < SMAX) m_starve++;
    end
    e_known = 1'b1;
    g_last  = g;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int cyc;
    rst = 1'b1; chk_addr1 = '0; chk_addr2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      v[i] = 1'b1; a[i] = AW'(i + 1); d[i] = 32'hA0 + i;
    end
    e_known = 1'b0; m_rr = 1; m_starve = 0; g_last = -1;
    e_we = 1'b0; e_waddr = '0; e_wdata = '0; e_chkdata = 1'b0;

    // Reset with every port requesting, then release.
    tick("t1_rst");
    tick("t1_rst");
    rst = 1'b0;
    tick("t1_rel");
    chk("t1_first", rdy_s, 3'b001);
    v[0] = 1'b0;
    tick("t1_drain"); v[g_last] = 1'b0;
    tick("t1_drain"); v[g_last] = 1'b0;
    tick("idle");

    // Single write from port 1.
    v[1] = 1'b1; a[1] = 5; d[1] = 32'h1234;
    tick("t2");
    chk("t2_rdy", rdy_s, 3'b010);
    v[1] = 1'b0;
    tick("t2_wr");
    chk("t2_we", we_s, 1'b1);
    chk("t2_waddr", wa_s, 5);
    chk("t2_wdata", wd_s, 32'h1234);

    // Round-robin between ports 1 and 2.
    v[1] = 1'b1; a[1] = 10; d[1] = $urandom;
    v[2] = 1'b1; a[2] = 11; d[2] = $urandom;
    for (int k = 0; k < 6; k++) begin
      tick("t3");
      if (k > 0) chk("t3_we", we_s, 1'b1);
      if (g_last >= 1) begin
        if (k == 5) v[g_last] = 1'b0;
        else begin
          a[g_last] = AW'($urandom_range(1, 31));
          d[g_last] = $urandom;
        end
      end
    end
    tick("t3_drain"); if (g_last >= 0) v[g_last] = 1'b0;
    tick("idle");

    // Starvation: port 0 always busy, port 2 waiting.
    v[0] = 1'b1; a[0] = 12; d[0] = $urandom;
    v[2] = 1'b1; a[2] = 9;  d[2] = $urandom;
    found = 1'b0; cyc = 0;
    while (!found && cyc < 20) begin
      cyc++;
      tick("t4");
      if (rdy_s[2]) begin
        found = 1'b1;
        chk("t4_cycle", cyc, 9);
        chk("t4_rdy0", rdy_s[0], 1'b0);
        chk("t4_starve", st_s, 1'b1);
        v[2] = 1'b0;
      end else d[0] = $urandom;
    end
    chk("t4_found", found, 1'b1);
    v[2] = 1'b0;
    tick("t4_resume");
    chk("t4_resume", rdy_s, 3'b001);
    v[0] = 1'b0;
    tick("idle");

    // Hazard reporting.
    v[0] = 1'b1; a[0] = 3; d[0] = $urandom;
    v[1] = 1'b1; a[1] = 7; d[1] = $urandom;
    chk_addr1 = 7; chk_addr2 = 9;
    tick("t5");
    chk("t5_hit", ph1_s, 1'b1);
    chk("t5_hit2", ph2_s, 1'b0);
    v[0] = 1'b0;
    tick("t5_gnt");
    chk("t5_rdy", rdy_s, 3'b010);
    chk("t5_nohit", ph1_s, 1'b0);
    v[0] = 1'b1; a[0] = 3; d[0] = $urandom;
    v[1] = 1'b1; a[1] = 0; d[1] = $urandom;
    chk_addr1 = 0;
    tick("t5_zero");
    chk("t5_zero", ph1_s, 1'b0);
    v[0] = 1'b0;
    tick("t5_drain"); v[1] = 1'b0;
    tick("idle");

    // Write to r0 is granted but discarded.
    v[0] = 1'b1; a[0] = 0; d[0] = 32'hFFFF_FFFF;
    tick("t6");
    chk("t6_rdy", rdy_s, 3'b001);
    v[0] = 1'b0;
    tick("t6_wr");
    chk("t6_we", we_s, 1'b0);

    // Reset right after a grant cancels the write after the reset edge.
    v[1] = 1'b1; a[1] = 6; d[1] = $urandom;
    tick("t7");
    v[1] = 1'b0; rst = 1'b1;
    tick("t7_rst");
    rst = 1'b0;
    tick("t7_after");
    chk("t7_we", we_s, 1'b0);

    // Random traffic; requesters hold until granted, small addresses force collisions.
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 59) == 0);
      chk_addr1 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 7)) : a[$urandom_range(1, NREQ - 1)];
      chk_addr2 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 7)) : a[$urandom_range(1, NREQ - 1)];
      tick("rnd");
      for (int i = 0; i < NREQ; i++) begin
        if (!v[i] || g_last == i) begin
          v[i] = (i == 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 1) == 1);
          a[i] = AW'($urandom_range(0, 7));
          d[i] = $urandom;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
